// File: rtl/data_cache_pkg.sv
// Shared types and address-field helpers for the direct-mapped data cache.
package data_cache_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 16;
  localparam int OFFSET_W = 2;
  localparam int INDEX_W  = 6;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVICT  = 2'd1,
    FILL   = 2'd2,
    UPDATE = 2'd3
  } cache_state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W-1:0];
  endfunction

endpackage

// File: rtl/data_cache_ram.sv
// Data array: one write port, one registered read port with read enable.
module data_cache_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_BITS-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [1<<ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register holds its value when re is low, so it doubles as the load result.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller with
// word-serial evict and refill over a req/ready memory handshake.
module data_cache_ctrl
  import data_cache_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_W,
  parameter int ADDR_WIDTH  = ADDR_W,
  parameter int OFFSET_BITS = OFFSET_W,
  parameter int INDEX_BITS  = INDEX_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_ren,
  input  logic                  data_wren,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0] cpu_data_in,
  output logic [DATA_WIDTH-1:0] cpu_data_out,
  output logic                  d_cache_read_miss,
  output logic                  d_cache_write_miss,
  output logic                  mem_req,
  output logic                  mem_wren,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic                  mem_ready
);

  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int RAM_AW   = INDEX_BITS + OFFSET_BITS;
  localparam logic [OFFSET_BITS-1:0] LAST_WORD = '1;

  cache_state_t           state;
  logic [LINES-1:0]       valid, dirty;
  logic [TAG_BITS-1:0]    tag_array [LINES];
  logic                   req_store;
  logic [TAG_BITS-1:0]    req_tag;
  logic [INDEX_BITS-1:0]  req_index;
  logic [OFFSET_BITS-1:0] word_cnt;

  logic [TAG_BITS-1:0]    cpu_tag;
  logic [INDEX_BITS-1:0]  cpu_index;
  logic                   hit, is_store, is_load, miss, victim_dirty, beat_done;

  logic                   ram_we, ram_re;
  logic [RAM_AW-1:0]      ram_waddr, ram_raddr;
  logic [DATA_WIDTH-1:0]  ram_wdata, ram_rdata;

  assign cpu_tag      = addr_tag(cpu_address);
  assign cpu_index    = addr_index(cpu_address);
  assign hit          = valid[cpu_index] && (tag_array[cpu_index] == cpu_tag);
  assign is_store     = data_wren;
  assign is_load      = data_ren & ~data_wren;
  assign miss         = (state == IDLE) && (data_ren || data_wren) && !hit;
  assign victim_dirty = valid[cpu_index] & dirty[cpu_index];
  assign beat_done    = mem_req & mem_ready;

  always_comb begin
    d_cache_read_miss  = 1'b0;
    d_cache_write_miss = 1'b0;
    if (state == IDLE) begin
      d_cache_read_miss  = is_load & ~hit;
      d_cache_write_miss = is_store & ~hit;
    end else begin
      d_cache_read_miss  = ~req_store;
      d_cache_write_miss = req_store;
    end
  end

  // The read port pre-fetches word 0 of a dirty victim on the miss edge so
  // mem_data_out is valid in the first EVICT cycle; the req gap after each
  // beat gives the next word time to arrive.
  assign ram_we    = ((state == IDLE) && is_store && hit) || ((state == FILL) && beat_done);
  assign ram_waddr = (state == FILL) ? {req_index, word_cnt} : cpu_address[RAM_AW-1:0];
  assign ram_wdata = (state == FILL) ? mem_data_in : cpu_data_in;
  assign ram_re    = ((state == IDLE) && is_load && hit) || (miss && victim_dirty) ||
                     (state == EVICT);
  assign ram_raddr = (state != IDLE) ? {req_index, word_cnt} :
                     hit ? cpu_address[RAM_AW-1:0] : {cpu_index, {OFFSET_BITS{1'b0}}};

  assign mem_address  = (state == EVICT) ? {tag_array[req_index], req_index, word_cnt}
                                         : {req_tag, req_index, word_cnt};
  assign mem_data_out = ram_rdata;
  assign cpu_data_out = ram_rdata;

  data_cache_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_BITS (RAM_AW)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      valid     <= '0;
      dirty     <= '0;
      mem_req   <= 1'b0;
      mem_wren  <= 1'b0;
      word_cnt  <= '0;
      req_store <= 1'b0;
      req_tag   <= '0;
      req_index <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_store && hit) dirty[cpu_index] <= 1'b1;
          if (miss) begin
            req_store <= is_store;
            req_tag   <= cpu_tag;
            req_index <= cpu_index;
            word_cnt  <= '0;
            mem_req   <= 1'b1;
            if (victim_dirty) begin
              state    <= EVICT;
              mem_wren <= 1'b1;
            end else begin
              state <= FILL;
            end
          end
        end
        EVICT: begin
          if (beat_done) begin
            mem_req  <= 1'b0;
            word_cnt <= word_cnt + 1'b1;
            if (word_cnt == LAST_WORD) begin
              state            <= FILL;
              mem_wren         <= 1'b0;
              dirty[req_index] <= 1'b0;
            end
          end else begin
            mem_req <= 1'b1;
          end
        end
        FILL: begin
          if (beat_done) begin
            mem_req  <= 1'b0;
            word_cnt <= word_cnt + 1'b1;
            if (word_cnt == LAST_WORD) state <= UPDATE;
          end else begin
            mem_req <= 1'b1;
          end
        end
        UPDATE: begin
          tag_array[req_index] <= req_tag;
          valid[req_index]     <= 1'b1;
          dirty[req_index]     <= 1'b0;
          state                <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Self-checking bench: flat-memory reference plus a line-residency model,
// with a behavioural memory that answers the req/ready handshake.
module tb_data_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_ren, data_wren;
  logic [15:0] cpu_address, cpu_data_in, cpu_data_out;
  logic        d_cache_read_miss, d_cache_write_miss;
  logic        mem_req, mem_wren, mem_ready;
  logic [15:0] mem_address, mem_data_out, mem_data_in;

  always #5 clk = ~clk;

  data_cache_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .data_ren          (data_ren),
    .data_wren         (data_wren),
    .cpu_address       (cpu_address),
    .cpu_data_in       (cpu_data_in),
    .cpu_data_out      (cpu_data_out),
    .d_cache_read_miss (d_cache_read_miss),
    .d_cache_write_miss(d_cache_write_miss),
    .mem_req           (mem_req),
    .mem_wren          (mem_wren),
    .mem_address       (mem_address),
    .mem_data_out      (mem_data_out),
    .mem_data_in       (mem_data_in),
    .mem_ready         (mem_ready)
  );

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [15:0] data;
  } txn_t;

  logic [15:0] ext  [0:65535];  // external memory contents
  logic [15:0] flat [0:65535];  // what the CPU should observe
  bit          mvalid [64];
  bit          mdirty [64];
  logic [7:0]  mtag   [64];
  txn_t        log_q [$];
  int          ready_delay;
  bit          rand_delay;
  bit          stab_bad;
  int          checks, errors;

  // Memory responder: acts on the falling edge, ready pulses for one cycle.
  initial begin
    int wcnt, dly;
    bit have;
    logic [15:0] sa, sd;
    logic sw;
    mem_ready = 1'b0; mem_data_in = '0; have = 0; wcnt = 0; dly = 0;
    sa = '0; sd = '0; sw = 1'b0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (rst !== 1'b0 || mem_req !== 1'b1) begin
        have = 0;
      end else begin
        if (!have) begin
          have = 1; wcnt = 0;
          sa = mem_address; sw = mem_wren; sd = mem_data_out;
          dly = rand_delay ? int'($urandom_range(3, 0)) : ready_delay;
        end else if (mem_address !== sa || mem_wren !== sw || (sw && mem_data_out !== sd)) begin
          stab_bad = 1;
        end
        if (wcnt >= dly) begin
          mem_ready = 1'b1;
          log_q.push_back('{addr: sa, wr: sw, data: sd});
          if (sw) ext[sa] = sd;
          else    mem_data_in = ext[sa];
          have = 0;
        end else begin
          wcnt++;
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin mvalid[i] = 0; mdirty[i] = 0; mtag[i] = '0; end
    for (int i = 0; i < 65536; i++) flat[i] = ext[i];
  endtask

  // One CPU access from request to completion; checks miss flags, memory
  // traffic and load data against the reference.
  task automatic cpu_access(input bit st, input logic [15:0] a, input logic [15:0] d, input bit both);
    int          idx, cyc;
    logic [5:0]  ix;
    logic [1:0]  kk;
    logic [7:0]  tg;
    logic [15:0] ea;
    bit          hit;
    txn_t        exp_q [$];
    idx = int'(a[7:2]); ix = a[7:2]; tg = a[15:8];
    hit = mvalid[idx] && (mtag[idx] == tg);
    if (!hit) begin
      if (mvalid[idx] && mdirty[idx])
        for (int k = 0; k < 4; k++) begin
          kk = k[1:0]; ea = {mtag[idx], ix, kk};
          exp_q.push_back('{addr: ea, wr: 1'b1, data: flat[ea]});
        end
      for (int k = 0; k < 4; k++) begin
        kk = k[1:0]; ea = {tg, ix, kk};
        exp_q.push_back('{addr: ea, wr: 1'b0, data: 16'h0});
      end
    end
    log_q.delete();
    stab_bad = 0;
    @(posedge clk); #1;
    data_ren = !st || both; data_wren = st; cpu_address = a; cpu_data_in = d;
    @(negedge clk);
    checks++;
    if (d_cache_read_miss !== (!st && !hit) || d_cache_write_miss !== (st && !hit)) begin
      errors++;
      $display("FAIL miss_flags addr=%h got rm=%b wm=%b want rm=%b wm=%b", a,
               d_cache_read_miss, d_cache_write_miss, !st && !hit, st && !hit);
    end
    cyc = 0;
    while ((d_cache_read_miss || d_cache_write_miss) && cyc < 1000) begin
      @(negedge clk); cyc++;
    end
    checks++;
    if (d_cache_read_miss !== 1'b0 || d_cache_write_miss !== 1'b0) begin
      errors++;
      $display("FAIL miss_timeout addr=%h got rm=%b wm=%b want both 0", a,
               d_cache_read_miss, d_cache_write_miss);
    end
    checks++;
    if (log_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL txn_count addr=%h got %0d want %0d", a, log_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (log_q[i].addr !== exp_q[i].addr || log_q[i].wr !== exp_q[i].wr ||
            (exp_q[i].wr && log_q[i].data !== exp_q[i].data)) begin
          errors++;
          $display("FAIL txn[%0d] got a=%h w=%b d=%h want a=%h w=%b d=%h", i,
                   log_q[i].addr, log_q[i].wr, log_q[i].data,
                   exp_q[i].addr, exp_q[i].wr, exp_q[i].data);
        end
      end
    end
    if (!hit) begin
      checks++;
      if (stab_bad) begin
        errors++;
        $display("FAIL mem_stable addr=%h got unstable want stable", a);
      end
      mvalid[idx] = 1; mtag[idx] = tg; mdirty[idx] = 0;
    end
    @(posedge clk); #1;
    if (st) begin
      flat[a] = d; mdirty[idx] = 1;
    end else begin
      checks++;
      if (cpu_data_out !== flat[a]) begin
        errors++;
        $display("FAIL load_data addr=%h got %h want %h", a, cpu_data_out, flat[a]);
      end
    end
    data_ren = 1'b0; data_wren = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; data_ren = 0; data_wren = 0; cpu_address = '0; cpu_data_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || mem_wren !== 1'b0) begin
      errors++; $display("FAIL reset_mem got req=%b wren=%b want 0 0", mem_req, mem_wren);
    end
    checks++;
    if (cpu_data_out !== 16'h0) begin
      errors++; $display("FAIL reset_data got %h want 0000", cpu_data_out);
    end
    checks++;
    if (d_cache_read_miss !== 1'b0 || d_cache_write_miss !== 1'b0) begin
      errors++; $display("FAIL reset_miss got %b%b want 00", d_cache_read_miss, d_cache_write_miss);
    end
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_read_miss();
    cpu_access(0, 16'h0123, 16'h0, 0);
  endtask

  task automatic test_read_hit();
    cpu_access(0, 16'h0121, 16'h0, 0);
  endtask

  task automatic test_write_hit_evict();
    cpu_access(1, 16'h0122, 16'hBEEF, 0);
    cpu_access(0, 16'h4122, 16'h0, 0);
    checks++;
    if (log_q.size() < 3 || log_q[2].data !== 16'hBEEF) begin
      errors++; $display("FAIL evict_beef got n=%0d want word2=BEEF", log_q.size());
    end
  endtask

  task automatic test_write_miss();
    cpu_access(1, 16'h2000, 16'hAAAA, 1);
    cpu_access(0, 16'h2000, 16'h0, 0);
    cpu_access(0, 16'h6000, 16'h0, 0);
    checks++;
    if (log_q.size() < 1 || log_q[0].data !== 16'hAAAA || log_q[0].wr !== 1'b1) begin
      errors++; $display("FAIL evict_aaaa got n=%0d want first write AAAA", log_q.size());
    end
  endtask

  task automatic test_slow_mem();
    ready_delay = 5;
    cpu_access(1, 16'h4121, 16'h1234, 0);
    cpu_access(0, 16'h8121, 16'h0, 0);
    ready_delay = 0;
  endtask

  task automatic test_reset_mid_fill();
    int cyc;
    ready_delay = 2;
    log_q.delete();
    @(posedge clk); #1;
    data_ren = 1'b1; data_wren = 1'b0; cpu_address = 16'h3A57;
    cyc = 0;
    while (log_q.size() < 2 && cyc < 200) begin @(negedge clk); cyc++; end
    checks++;
    if (log_q.size() != 2) begin
      errors++; $display("FAIL midfill_progress got %0d want 2", log_q.size());
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mem_req !== 1'b0 || mem_wren !== 1'b0) begin
      errors++; $display("FAIL midfill_abort got req=%b wren=%b want 0 0", mem_req, mem_wren);
    end
    rst = 1'b0; data_ren = 1'b0;
    model_reset();
    ready_delay = 0;
    cpu_access(0, 16'h3A57, 16'h0, 0);
  endtask

  task automatic test_random();
    logic [7:0]  tags [4];
    logic [5:0]  idxs [4];
    logic [5:0]  ix;
    logic [1:0]  off;
    logic [15:0] a;
    bit          st;
    tags = '{8'h00, 8'h41, 8'h20, 8'h9C};
    idxs = '{6'd8, 6'd0, 6'd21, 6'd33};
    rand_delay = 1;
    for (int n = 0; n < 150; n++) begin
      ix  = idxs[$urandom_range(3, 0)];
      off = 2'($urandom_range(3, 0));
      a   = {tags[$urandom_range(3, 0)], ix, off};
      st  = ($urandom_range(2, 0) == 0);
      cpu_access(st, a, 16'($urandom), ($urandom_range(1, 0) == 1));
    end
    rand_delay = 0;
  endtask

  initial begin
    checks = 0; errors = 0; ready_delay = 0; rand_delay = 0; stab_bad = 0;
    for (int i = 0; i < 65536; i++) ext[i] = 16'($urandom);
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_hit_evict();
    test_write_miss();
    test_slow_mem();
    test_reset_mid_fill();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
